// File: rtl/memory_dump_streamer.sv
// Streams a framed little-endian dump of the tracked write window:
// an 8-byte header (start address, word count) followed by each word read from data memory.
module memory_dump_streamer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] min_addr_i,
  input  logic [31:0] max_addr_i,
  output logic        rd_en_o,
  output logic [31:0] rd_addr_o,
  input  logic [31:0] rd_data_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {IDLE, HDR, RD_REQ, RD_WAIT, SEND, DONE} state_t;

  state_t      state;
  logic [31:0] base_q;
  logic [31:0] count_q;
  logic [31:0] cur_addr_q;
  logic [31:0] remaining_q;
  logic [31:0] word_q;
  logic [2:0]  idx_q;

  logic        handshake;
  logic        empty_range;
  logic [31:0] min_base;
  logic [31:0] max_last;
  logic [31:0] span_count;
  logic [2:0]  idx_next;
  logic [31:0] next_addr;

  assign handshake   = tx_valid_o && tx_ready_i;
  // The tracker's flushed state (min > max) means nothing was written.
  assign empty_range = min_addr_i > max_addr_i;
  assign min_base    = {min_addr_i[31:2], 2'b00};
  assign max_last    = {max_addr_i[31:2], 2'b00};
  assign span_count  = ((max_last - min_base) >> 2) + 32'd1;
  assign idx_next    = idx_q + 3'd1;
  assign next_addr   = cur_addr_q + 32'd4;

  function automatic logic [7:0] pick_byte(input logic [1:0] sel, input logic [31:0] w);
    logic [7:0] b;
    case (sel)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      rd_en_o     <= 1'b0;
      rd_addr_o   <= '0;
      tx_data_o   <= '0;
      tx_valid_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            base_q     <= empty_range ? 32'd0 : min_base;
            count_q    <= empty_range ? 32'd0 : span_count;
            tx_data_o  <= empty_range ? 8'd0 : min_base[7:0];
            idx_q      <= 3'd0;
            tx_valid_o <= 1'b1;
            busy_o     <= 1'b1;
            state      <= HDR;
          end
        end
        HDR: begin
          if (handshake) begin
            if (idx_q == 3'd7) begin
              tx_valid_o <= 1'b0;
              if (count_q == 32'd0) begin
                done_o <= 1'b1;
                state  <= DONE;
              end else begin
                cur_addr_q  <= base_q;
                remaining_q <= count_q;
                rd_en_o     <= 1'b1;
                rd_addr_o   <= base_q;
                state       <= RD_REQ;
              end
            end else begin
              idx_q     <= idx_next;
              tx_data_o <= pick_byte(idx_next[1:0], idx_next[2] ? count_q : base_q);
            end
          end
        end
        RD_REQ: begin
          rd_en_o <= 1'b0;
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          word_q     <= rd_data_i;
          tx_data_o  <= rd_data_i[7:0];
          tx_valid_o <= 1'b1;
          idx_q      <= 3'd0;
          state      <= SEND;
        end
        SEND: begin
          if (handshake) begin
            if (idx_q[1:0] == 2'd3) begin
              // Termination follows the word counter; the address may wrap past FFFF_FFFC.
              tx_valid_o  <= 1'b0;
              remaining_q <= remaining_q - 32'd1;
              cur_addr_q  <= next_addr;
              if (remaining_q == 32'd1) begin
                done_o <= 1'b1;
                state  <= DONE;
              end else begin
                rd_en_o   <= 1'b1;
                rd_addr_o <= next_addr;
                state     <= RD_REQ;
              end
            end else begin
              idx_q     <= idx_next;
              tx_data_o <= pick_byte(idx_next[1:0], word_q);
            end
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_dump_streamer.sv
// Scoreboard bench for memory_dump_streamer: stimulus queues expected bytes and reads,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_memory_dump_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [31:0] min_addr_i;
  logic [31:0] max_addr_i;
  logic        rd_en_o;
  logic [31:0] rd_addr_o;
  logic [31:0] rd_data_i = 32'd0;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rd_q[$];
  int bytes_acc = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  bit stall_en = 0;
  bit rand_en = 0;
  bit stalled3 = 0;
  bit stalled17 = 0;
  bit prev_hold = 0;
  logic [7:0] prev_data = 8'd0;

  always #5 clk = ~clk;

  memory_dump_streamer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .min_addr_i (min_addr_i),
    .max_addr_i (max_addr_i),
    .rd_en_o    (rd_en_o),
    .rd_addr_o  (rd_addr_o),
    .rd_data_i  (rd_data_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0100: return 32'h1122_3344;
      32'h0000_0104: return 32'hAABB_CCDD;
      32'h0000_0108: return 32'h0102_0304;
      32'hFFFF_FFF8: return 32'hCAFE_BABE;
      32'hFFFF_FFFC: return 32'h0BAD_F00D;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Synchronous read port: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en_o) rd_data_i <= mem_word(rd_addr_o);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: stream handshakes, read strobes, hold stability and done pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checkOutput("valid_held", 32'(tx_valid_o), 32'd1);
        checkOutput("data_stable", 32'(tx_data_o), 32'(prev_data));
      end
      if (tx_valid_o && tx_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL tx_extra: got byte %h, required no byte", tx_data_o);
        end else begin
          checkOutput("tx_byte", 32'(tx_data_o), 32'(exp_q.pop_front()));
        end
        bytes_acc++;
      end
      if (rd_en_o) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rd_extra: got read at %h, required no read", rd_addr_o);
        end else begin
          checkOutput("rd_addr", rd_addr_o, rd_q.pop_front());
        end
      end
      if (done_o) begin
        done_cnt++;
        checkOutput("done_drained", 32'(exp_q.size() + rd_q.size()), 32'd0);
      end
      prev_hold = tx_valid_o && !tx_ready_i;
      prev_data = tx_data_o;
    end
  end

  // Ready driver: always ready, optionally random, with 5-cycle stalls at frame bytes 3 and 17.
  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin
      tx_ready_i = 1'b0;
      stall_cnt--;
    end else if (stall_en && tx_valid_o &&
                 ((bytes_acc == 3 && !stalled3) || (bytes_acc == 17 && !stalled17))) begin
      if (bytes_acc == 3) stalled3 = 1'b1;
      else stalled17 = 1'b1;
      tx_ready_i = 1'b0;
      stall_cnt = 4;
    end else begin
      tx_ready_i = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic pushWord(input logic [31:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[31:24]);
  endtask

  task automatic applyStimulus(input logic [31:0] min_a, input logic [31:0] max_a,
                               input logic [31:0] exp_base, input logic [31:0] exp_count,
                               input int n, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2);
    logic [31:0] words [3];
    words[0] = w0;
    words[1] = w1;
    words[2] = w2;
    pushWord(exp_base);
    pushWord(exp_count);
    for (int i = 0; i < n; i++) begin
      pushWord(words[i]);
      rd_q.push_back(exp_base + 32'(4 * i));
    end
    bytes_acc = 0;
    @(posedge clk);
    #1;
    min_addr_i = min_a;
    max_addr_i = max_a;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    min_addr_i = 32'h0000_0000;
    max_addr_i = 32'hFFFF_FFF0;
    checkOutput("start_valid", 32'(tx_valid_o), 32'd1);
    checkOutput("start_busy", 32'(busy_o), 32'd1);
  endtask

  task automatic waitDone(input int d0, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_o) break;
    end
    if (i == budget) begin
      checkOutput("done_timeout", 32'(done_o), 32'd1);
    end else begin
      checkOutput("busy_in_done", 32'(busy_o), 32'd1);
      @(negedge clk);
      checkOutput("busy_fall", 32'(busy_o), 32'd0);
      checkOutput("done_width", 32'(done_o), 32'd0);
      checkOutput("done_count", 32'(done_cnt), 32'(d0 + 1));
    end
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    start_i = 1'b0;
    min_addr_i = 32'd0;
    max_addr_i = 32'd0;
    #12;
    checkOutput("rst_rd_en", 32'(rd_en_o), 32'd0);
    checkOutput("rst_rd_addr", rd_addr_o, 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data_o), 32'd0);
    checkOutput("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] basic dump");
    d0 = done_cnt;
    applyStimulus(32'h100, 32'h108, 32'h100, 32'd3, 3, 32'h1122_3344, 32'hAABB_CCDD, 32'h0102_0304);
    waitDone(d0, 300);

    $display("[TB] empty range");
    d0 = done_cnt;
    applyStimulus(32'hFFFF_FFFF, 32'h0, 32'h0, 32'd0, 0, 32'h0, 32'h0, 32'h0);
    waitDone(d0, 300);

    $display("[TB] unaligned inputs");
    d0 = done_cnt;
    applyStimulus(32'h103, 32'h106, 32'h100, 32'd2, 2, 32'h1122_3344, 32'hAABB_CCDD, 32'h0);
    waitDone(d0, 300);

    $display("[TB] backpressure");
    stall_en = 1'b1;
    rand_en = 1'b1;
    stalled3 = 1'b0;
    stalled17 = 1'b0;
    d0 = done_cnt;
    applyStimulus(32'h100, 32'h108, 32'h100, 32'd3, 3, 32'h1122_3344, 32'hAABB_CCDD, 32'h0102_0304);
    waitDone(d0, 1000);
    stall_en = 1'b0;
    rand_en = 1'b0;
    checkOutput("stalls_hit", 32'({stalled3, stalled17}), 32'd3);

    $display("[TB] start mid-frame");
    d0 = done_cnt;
    applyStimulus(32'h100, 32'h108, 32'h100, 32'd3, 3, 32'h1122_3344, 32'hAABB_CCDD, 32'h0102_0304);
    repeat (3) @(posedge clk);
    #1;
    min_addr_i = 32'h0;
    max_addr_i = 32'h40;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    waitDone(d0, 300);

    $display("[TB] reset mid-dump");
    applyStimulus(32'h100, 32'h108, 32'h100, 32'd3, 3, 32'h1122_3344, 32'hAABB_CCDD, 32'h0102_0304);
    for (int i = 0; i < 200 && bytes_acc < 10; i++) @(negedge clk);
    checkOutput("reach_send", 32'(bytes_acc >= 10), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_rd_en", 32'(rd_en_o), 32'd0);
    checkOutput("mid_rst_rd_addr", rd_addr_o, 32'd0);
    checkOutput("mid_rst_tx_data", 32'(tx_data_o), 32'd0);
    checkOutput("mid_rst_tx_valid", 32'(tx_valid_o), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("mid_rst_done", 32'(done_o), 32'd0);
    exp_q.delete();
    rd_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    d0 = done_cnt;
    applyStimulus(32'h100, 32'h108, 32'h100, 32'd3, 3, 32'h1122_3344, 32'hAABB_CCDD, 32'h0102_0304);
    waitDone(d0, 300);

    $display("[TB] top of address space");
    d0 = done_cnt;
    applyStimulus(32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'd2, 2, 32'hCAFE_BABE, 32'h0BAD_F00D, 32'h0);
    waitDone(d0, 300);
    repeat (10) @(posedge clk);
    checkOutput("idle_after_top", 32'(busy_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
